// File: rtl/aes_core.sv
// aes_core: iterative AES-128 block, one round per clock, round keys derived
// on the fly from the previous round key (no stored schedule).
//
// Parameter
//   CIPHER   1 = encrypt, 0 = decrypt (fixed at elaboration)
// Ports
//   clk       in   single clock, rising edge
//   rst_n     in   synchronous reset, ACTIVE HIGH (1 = reset) despite the name
//   data_in   in   128b plaintext (encrypt) / ciphertext (decrypt)
//   key       in   128b cipher key (encrypt) / round-10 key (decrypt)
//   data_out  out  128b registered result, held between finished pulses
//   finished  out  one-cycle pulse when data_out carries a new result
//
// Byte b of a 128-bit block lives in bits [127-8b -: 8]; b = 4*col + row.
// Free-running schedule: DONE -> LOAD -> ROUND x10 -> DONE, 12 cycles/block.
`timescale 1ns/1ps
module aes_core #(
    parameter int CIPHER = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] data_in,
    input  logic [127:0] key,
    output logic [127:0] data_out,
    output logic         finished
);

    typedef enum logic [1:0] {S_LOAD, S_ROUND, S_DONE} fsm_t;

    fsm_t         fsm_q;
    logic [127:0] state_q, rk_q, data_out_q;
    logic [3:0]   rnd_q;
    logic         finished_q;
    logic [127:0] round_d, rkey_d;

    // ---------------- GF(2^8) helpers ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // a^254 == a^-1 (and maps 0 to 0, as the S-box needs)
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq, acc;
        sq  = gf_mul(a, a);
        acc = sq;
        for (int i = 2; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

    // ---------------- state transforms ----------------
    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int b = 0; b < 16; b++) o[127-8*b -: 8] = sbox(s[127-8*b -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int b = 0; b < 16; b++) o[127-8*b -: 8] = inv_sbox(s[127-8*b -: 8]);
        return o;
    endfunction

    // Row r rotates left by r columns; inverse rotates right.
    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        int src;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                src = inv ? ((c - r + 4) % 4) : ((c + r) % 4);
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*src+r) -: 8];
            end
        return o;
    endfunction

    // Circulant column multiply; m packs the first matrix row {m0,m1,m2,m3}.
    function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic [31:0] m);
        logic [127:0] o;
        logic [7:0]   acc;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gf_mul(m[31-8*((j-r+4)%4) -: 8], s[127-8*(4*c+j) -: 8]);
                o[127-8*(4*c+r) -: 8] = acc;
            end
        return o;
    endfunction

    // ---------------- key expansion ----------------
    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // SubWord(RotWord(w))
    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] fwd_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0]  ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Undo one expansion step: recover the previous round key from this one.
    function automatic logic [127:0] inv_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0]  ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ sub_rot(w3) ^ {rc, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

    // ---------------- round datapath ----------------
    generate
        if (CIPHER != 0) begin : g_enc
            logic [127:0] sr_w;
            assign rkey_d  = fwd_key(rk_q, rcon(rnd_q));
            assign sr_w    = shift_rows(sub_bytes(state_q), 1'b0);
            assign round_d = ((rnd_q == 4'd10) ? sr_w : mix_cols(sr_w, 32'h02030101)) ^ rkey_d;
        end else begin : g_dec
            logic [127:0] ark_w;
            // Decrypt walks keys 9..0, so Rcon runs backwards: 36,1b,...,01.
            assign rkey_d  = inv_key(rk_q, rcon(4'd11 - rnd_q));
            assign ark_w   = inv_sub_bytes(shift_rows(state_q, 1'b1)) ^ rkey_d;
            assign round_d = (rnd_q == 4'd10) ? ark_w : mix_cols(ark_w, 32'h0e0b0d09);
        end
    endgenerate

    // ---------------- control ----------------
    // Reset parks the FSM in DONE (finished low) so the first clock after
    // release enters LOAD, and the next one samples the inputs.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            fsm_q      <= S_DONE;
            state_q    <= '0;
            rk_q       <= '0;
            rnd_q      <= 4'd0;
            data_out_q <= '0;
            finished_q <= 1'b0;
        end else begin
            finished_q <= 1'b0;
            case (fsm_q)
                S_LOAD: begin
                    state_q <= data_in ^ key;
                    rk_q    <= key;
                    rnd_q   <= 4'd1;
                    fsm_q   <= S_ROUND;
                end
                S_ROUND: begin
                    state_q <= round_d;
                    rk_q    <= rkey_d;
                    if (rnd_q == 4'd10) begin
                        data_out_q <= round_d;
                        finished_q <= 1'b1;
                        rnd_q      <= 4'd0;
                        fsm_q      <= S_DONE;
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                S_DONE:  fsm_q <= S_LOAD;
                default: fsm_q <= S_DONE;
            endcase
        end
    end

    assign data_out = data_out_q;
    assign finished = finished_q;

endmodule

// File: tb/tb_aes_core.sv
// Bench for aes_core: one encrypt and one decrypt instance run side by side.
// Reference is a byte-array AES-128 encryptor with a table S-box and a full
// key schedule; decrypt expectations come from encrypting a known plaintext
// and handing the decryptor the ciphertext plus the final round key.
`timescale 1ns/1ps
module tb_aes_core;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] din_e, key_e, din_d, key_d;
    logic [127:0] out_e, out_d;
    logic         fin_e, fin_d;
    logic [127:0] held_e, held_d;
    logic [7:0]   sb [256];
    int           nvec = 0;
    int           nerr = 0;

    always #5 clk = ~clk;

    aes_core #(.CIPHER(1)) u_enc (
        .clk(clk), .rst_n(rst), .data_in(din_e), .key(key_e),
        .data_out(out_e), .finished(fin_e)
    );

    aes_core #(.CIPHER(0)) u_dec (
        .clk(clk), .rst_n(rst), .data_in(din_d), .key(key_d),
        .data_out(out_d), .finished(fin_d)
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box via walking the multiplicative group with generator 3.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] k,
                                             output logic [127:0] last_rk);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [31:0]  tmp;
        logic [127:0] o;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
                rc  = xtime(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int rw = 0; rw < 4; rw++) s[4*c+rw] = t[4*((c+rw)%4)+rw];
            if (r < 10)
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                    s[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
                end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r+i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        last_rk = {w[40], w[41], w[42], w[43]};
        return o;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_rand(output logic [127:0] ee, output logic [127:0] ed);
        logic [127:0] p, k, c, rk;
        p = {$urandom, $urandom, $urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        c = aes_enc(p, k, rk);
        din_e = p; key_e = k;
        din_d = c; key_d = rk;
        ee = c;
        ed = p;
    endtask

    // Waits (bounded) for the finished pulse, expecting it on edge 'lat'.
    // Outputs must hold their last value until then. Consumes one extra edge
    // to confirm the pulse is a single cycle; that edge is DONE->LOAD, so the
    // following LOAD samples whatever the caller drives next.
    task automatic wait_pulse(input string tag, input int lat,
                              input logic [127:0] ee, input logic [127:0] ed);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < lat + 4) begin
            @(posedge clk); #1;
            n++;
            if (fin_e || fin_d) seen = 1'b1;
            else begin
                chk({tag, "/hold_e"}, out_e, held_e);
                chk({tag, "/hold_d"}, out_d, held_d);
            end
        end
        chk({tag, "/latency"}, 128'(n), 128'(lat));
        chk({tag, "/fin_both"}, {126'd0, fin_e, fin_d}, 128'd3);
        chk({tag, "/enc"}, out_e, ee);
        chk({tag, "/dec"}, out_d, ed);
        held_e = ee;
        held_d = ed;
        @(posedge clk); #1;
        chk({tag, "/fin_1cyc"}, {126'd0, fin_e, fin_d}, 128'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [127:0] eb, db, ec, dc;
        build_sbox();
        held_e = '0;
        held_d = '0;

        // Reset with the first known-answer pair already on the inputs.
        rst   = 1'b1;
        din_e = 128'h00112233445566778899aabbccddeeff;
        key_e = 128'h000102030405060708090a0b0c0d0e0f;
        din_d = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        key_d = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        repeat (3) @(posedge clk);
        #1;
        chk("rst/out_e", out_e, 128'd0);
        chk("rst/out_d", out_d, 128'd0);
        chk("rst/fin", {126'd0, fin_e, fin_d}, 128'd0);

        @(negedge clk) rst = 1'b0;
        wait_pulse("kat1", 12, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                               128'h00112233445566778899aabbccddeeff);

        din_e = 128'h3243f6a8885a308d313198a2e0370734;
        key_e = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        din_d = 128'h3925841d02dc09fbdc118597196a0b32;
        key_d = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        wait_pulse("kat2", 11, 128'h3925841d02dc09fbdc118597196a0b32,
                               128'h3243f6a8885a308d313198a2e0370734);

        // Inputs swapped mid-block: current result uses the sampled set.
        set_rand(eb, db);
        repeat (4) @(posedge clk);
        #1;
        set_rand(ec, dc);
        wait_pulse("midchg", 7, eb, db);
        wait_pulse("newin", 11, ec, dc);

        // Reset during round 5 aborts the block and clears the outputs.
        set_rand(eb, db);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstmid/out_e", out_e, 128'd0);
        chk("rstmid/out_d", out_d, 128'd0);
        chk("rstmid/fin", {126'd0, fin_e, fin_d}, 128'd0);
        repeat (2) @(posedge clk);
        held_e = '0;
        held_d = '0;
        @(negedge clk) rst = 1'b0;
        wait_pulse("rstmid", 12, eb, db);

        for (int i = 0; i < 8; i++) begin
            set_rand(eb, db);
            wait_pulse("rand", 11, eb, db);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/aes_core.md
AES_CORE -- requirements
Module: aes_core

Interface
REQ-001 Parameter: CIPHER, default 1; 1 = AES-128 encryption, 0 = AES-128 decryption (fixed at elaboration).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-high despite the name (1 = reset).
REQ-004 data_in  input  128  plaintext when CIPHER=1, ciphertext when CIPHER=0.
REQ-005 key  input  128  cipher key when CIPHER=1; final (round-10) round key when CIPHER=0.
REQ-006 data_out  output  128  result block, registered.
REQ-007 finished  output  1  one-cycle pulse, high when data_out holds a new valid result.

Function
REQ-008 Byte order SHALL follow FIPS-197: bits[127:120] = byte 0; state loaded column-major.
REQ-009 Core SHALL be iterative: one round per clock, with round keys generated on the fly and no stored key schedule.
REQ-010 FSM states SHALL be LOAD, ROUND, DONE; the core SHALL enter LOAD on the first clock after reset is released.
REQ-011 LOAD (cycle 0) SHALL sample data_in and key, set state = data_in XOR key, set round key = key, and set round counter = 1.
REQ-012 ROUND (cycles 1..10), CIPHER=1: SubBytes, ShiftRows, MixColumns (skipped at round 10), then AddRoundKey with next forward-expanded key (Rcon 01,02,04,...,36).
REQ-013 ROUND (cycles 1..10), CIPHER=0: InvShiftRows, InvSubBytes, AddRoundKey with previous key via inverse expansion, then InvMixColumns (skipped at round 10).
REQ-014 After round 10, data_out SHALL load the final state and finished SHALL be 1 for exactly one cycle (DONE, cycle 11).
REQ-015 DONE SHALL transition to LOAD unconditionally, so the core free-runs; every block takes 12 cycles from LOAD to the finished pulse.
REQ-016 data_in and key changes during ROUND SHALL have no effect until the next LOAD.
REQ-017 data_out SHALL hold its value between finished pulses.
REQ-018 Round counter SHALL be 4 bits and SHALL never exceed 10.
REQ-019 S-box and inverse S-box SHALL be combinational (table or GF(2^8) logic); the implementation SHALL need no multi-cycle memory.

Reset
REQ-020 While rst_n=1 at a clock edge: data_out=0, finished=0, round counter=0, state register=0, FSM held before LOAD.
REQ-021 Reset asserted mid-operation SHALL abort the block with no finished pulse; processing SHALL restart with LOAD after release.

Verification
REQ-022 CIPHER=1, data_in=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f -> finished 12 cycles after reset release, data_out=69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-023 CIPHER=1, data_in=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c -> data_out=3925841d02dc09fbdc118597196a0b32.
REQ-024 CIPHER=0, data_in=3925841d02dc09fbdc118597196a0b32, key=d014f9a8c9ee2589e13f0cc8b6630ca6 -> data_out=3243f6a8885a308d313198a2e0370734.
REQ-025 CIPHER=0, data_in=69c4e0d86a7b0430d8cdb78070b4c55a, key=13111d7fe3944a17f307a78b4d2b30c5 -> data_out=00112233445566778899aabbccddeeff.
REQ-026 Inputs changed mid-block -> the current result is unchanged; the next finished pulse, 12 cycles later, reflects the new inputs; finished is never high for 2 consecutive cycles.
REQ-027 Reset asserted at round 5 -> data_out=0 and finished=0 immediately; after release, the correct result is returned 12 cycles later.
